// File: rtl/load_store_unit.sv
// Load/store initiator for a word-addressed data memory with combinational read.
// Handles byte/half/word loads with extension and sub-word stores via read-modify-write.
module load_store_unit #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);

    // state    | meaning
    // IDLE     | waiting for a request
    // LOAD     | memory read in progress, lane selected and extended
    // RMW_READ | old word read, target lane merged with store data
    // WRITE    | mem_we asserted for one cycle
    // RESP     | response presented until consumed
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_READ,
        WRITE,
        RESP
    } state_t;

    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic        accept;
    logic        req_err;

    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] size,
                                                input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (size)
            2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] w, input logic [1:0] size,
                                               input logic [1:0] lane, input logic [15:0] d);
        logic [31:0] r;
        r = w;
        if (size == 2'b00)
            r[{lane, 3'b000} +: 8] = d[7:0];
        else
            r[{lane[1], 4'b0000} +: 16] = d;
        return r;
    endfunction

    assign req_ready  = (state == IDLE) && !rst;
    assign resp_valid = (state == RESP);
    assign mem_we     = (state == WRITE) && !rst;
    assign accept     = req_valid && req_ready;

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = (req_addr[1:0] != 2'b00);
            2'b11:   req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
        if (req_addr[31:2] >= WORD_LIMIT)
            req_err = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_nxt = RESP;
                    else if (!req_we)
                        state_nxt = LOAD;
                    else if (req_size == 2'b10)
                        state_nxt = WRITE;
                    else
                        state_nxt = RMW_READ;
                end
            end
            LOAD:     state_nxt = RESP;
            RMW_READ: state_nxt = WRITE;
            WRITE:    state_nxt = RESP;
            RESP:     if (resp_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // mem_wd takes the full store word at accept; sub-word stores overwrite it with the merge.
    always_ff @(posedge clk) begin
        if (rst) begin
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            lane_q     <= 2'b00;
            wdata_q    <= 16'h0;
            mem_addr   <= 32'h0;
            mem_wd     <= 32'h0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        size_q     <= req_size;
                        uns_q      <= req_unsigned;
                        lane_q     <= req_addr[1:0];
                        wdata_q    <= req_wdata[15:0];
                        mem_addr   <= {req_addr[31:2], 2'b00};
                        mem_wd     <= req_wdata;
                        resp_rdata <= 32'h0;
                        resp_err   <= req_err;
                    end
                end
                LOAD:     resp_rdata <= load_extend(mem_rd, size_q, lane_q, uns_q);
                RMW_READ: mem_wd     <= merge_lane(mem_rd, size_q, lane_q, wdata_q);
                default:  ;
            endcase
        end
    end

endmodule
